uart_tx_buffer: RTL and testbench

- Byte FIFO plus launch state machine between the processor core's UART transmit strobe (start_TX/tx_data) and UART_TX.
- Lets software write bursts of bytes without polling tx_active before each byte.
- Drains bytes into UART_TX one at a time: pulses start_TX, then waits for the byte to finish on tx_active.
- Returns an aggregate busy status that the core reads in place of the raw tx_active.

---
 rtl/uart_tx_buffer.sv | 147 ++++++++++++++
 tb/tb_uart_tx_buffer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO in front of UART_TX with a launch state machine.
// Software writes bursts into the FIFO; the machine drains one byte at a time,
// pulsing start_TX and tracking tx_active, and reports aggregate busy status.
module uart_tx_buffer #(
    parameter int DEPTH_BITS   = 4,
    parameter int RISE_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic [DEPTH_BITS:0]   count,
    output logic                  tx_busy,
    output logic                  overflow,
    output logic                  tx_timeout,
    input  logic                  flag_clr,
    output logic                  start_TX,
    output logic [7:0]            tx_data,
    input  logic                  tx_active
);

    localparam int DEPTH = 2 ** DEPTH_BITS;
    localparam int TW    = (RISE_TIMEOUT > 1) ? $clog2(RISE_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_RISE = 2'd2,
        WAIT_FALL = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic [TW-1:0]         tmr_q, tmr_d;
    logic                  start_q, start_d;
    logic [7:0]            data_q, data_d;
    logic                  ovf_q, ovf_d;
    logic                  to_q, to_d;
    logic [7:0]            mem_q [DEPTH];

    logic                  push;
    logic                  drop;
    logic                  pop;
    logic                  to_set;

    assign full       = (count_q == (DEPTH_BITS + 1)'(DEPTH));
    assign count      = count_q;
    assign tx_busy    = (count_q != '0) || (state_q != IDLE) || tx_active;
    assign overflow   = ovf_q;
    assign tx_timeout = to_q;
    assign start_TX   = start_q;
    assign tx_data    = data_q;

    assign push = wr_en && !full;
    assign drop = wr_en && full;

    // Launch FSM next-state: pop only on IDLE->LAUNCH, timeout while waiting for rise
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        pop     = 1'b0;
        to_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if ((count_q != '0) && !tx_active) begin
                    state_d = LAUNCH;
                    pop     = 1'b1;
                end
            end
            LAUNCH: begin
                tmr_d   = '0;
                state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (tx_active) begin
                    state_d = WAIT_FALL;
                end else if (tmr_q == TW'(RISE_TIMEOUT - 1)) begin
                    to_set  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            WAIT_FALL: begin
                if (!tx_active) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // start_TX is registered, so it is high exactly while state_q == LAUNCH
        start_d = (state_d == LAUNCH);
    end

    // FIFO pointers, occupancy, output byte and sticky flags next-state
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        data_d = pop ? mem_q[rd_ptr_q] : data_q;
        // a new event in the same cycle as flag_clr keeps the flag set
        ovf_d  = drop   | (ovf_q & ~flag_clr);
        to_d   = to_set | (to_q  & ~flag_clr);
    end

    // Control and status registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tmr_q    <= '0;
            start_q  <= 1'b0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            tmr_q    <= tmr_d;
            start_q  <= start_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            to_q     <= to_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push && reset_n) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Testbench for uart_tx_buffer: scoreboard of expected launched bytes checked
// by a monitor on every start_TX pulse, plus directed status checks.
module tb_uart_tx_buffer;

    localparam int DEPTH_BITS   = 4;
    localparam int RISE_TIMEOUT = 16;
    localparam int ACT_LEN      = 20;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                wr_en;
    logic [7:0]          wr_data;
    logic                full;
    logic [DEPTH_BITS:0] count;
    logic                tx_busy;
    logic                overflow;
    logic                tx_timeout;
    logic                flag_clr;
    logic                start_TX;
    logic [7:0]          tx_data;
    logic                tx_active = 1'b0;

    logic                force_hi = 1'b0;
    logic                never    = 1'b0;
    int                  rem      = 0;
    int                  cyc      = 0;
    int                  compared   = 0;
    int                  mismatched = 0;
    logic [7:0]          exp_q [$];
    logic                prev_start = 1'b0;

    uart_tx_buffer #(
        .DEPTH_BITS   (DEPTH_BITS),
        .RISE_TIMEOUT (RISE_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .count      (count),
        .tx_busy    (tx_busy),
        .overflow   (overflow),
        .tx_timeout (tx_timeout),
        .flag_clr   (flag_clr),
        .start_TX   (start_TX),
        .tx_data    (tx_data),
        .tx_active  (tx_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // UART_TX model: busy from the cycle after start_TX for ACT_LEN cycles
    always @(posedge clk) begin
        if (force_hi) begin
            tx_active <= 1'b1;
            rem       <= 0;
        end else if (never) begin
            tx_active <= 1'b0;
            rem       <= 0;
        end else if (start_TX) begin
            tx_active <= 1'b1;
            rem       <= ACT_LEN - 1;
        end else if (rem != 0) begin
            rem <= rem - 1;
        end else begin
            tx_active <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Monitor: every launch must be a single-cycle pulse, never while UART is busy,
    // and carry the next byte expected by the scoreboard
    always @(negedge clk) begin
        if (start_TX) begin
            check("start_pulse_width", {31'd0, prev_start}, 0);
            check("no_start_while_active", {31'd0, tx_active}, 0);
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_start: got tx_data %02h expected no launch (cycle %0d)", tx_data, cyc);
            end else begin
                check("tx_data_order", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_start = start_TX;
    end

    task automatic do_reset();
        reset_n  = 1'b0;
        wr_en    = 1'b0;
        flag_clr = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic put(input logic [7:0] b, input bit expect_tx);
        wr_en   = 1'b1;
        wr_data = b;
        if (expect_tx) exp_q.push_back(b);
        @(negedge clk);
    endtask

    task automatic stop_wr();
        wr_en = 1'b0;
    endtask

    task automatic pulse_clr();
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
    endtask

    task automatic drain(input string name);
        int unsigned n;
        n = 0;
        while (tx_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (tx_busy) bound_fail(name);
    endtask

    task automatic wait_act(input logic level, input string name);
        int unsigned n;
        n = 0;
        while (tx_active !== level && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (tx_active !== level) bound_fail(name);
    endtask

    task automatic wait_start(input string name, output int at);
        int unsigned n;
        n = 0;
        while (!start_TX && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!start_TX) bound_fail(name);
        at = cyc;
    endtask

    task automatic wait_timeout(input string name, output int at);
        int unsigned n;
        n = 0;
        while (!tx_timeout && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!tx_timeout) bound_fail(name);
        at = cyc;
    endtask

    initial begin
        int t0, t1, t2, bad;
        reset_n  = 1'b1;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        flag_clr = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_timeout", tx_timeout, 0);
        check("rst_start", start_TX, 0);
        check("rst_tx_data", tx_data, 0);

        // Single byte: count=1 after write edge, start_TX in the cycle after the next edge
        put(8'h55, 1'b1);
        stop_wr();
        check("t1_count_after_write", count, 1);
        @(negedge clk);
        check("t1_start_latency", start_TX, 1);
        check("t1_tx_data", tx_data, 8'h55);
        check("t1_busy", tx_busy, 1);
        drain("t1_drain");
        check("t1_count_zero", count, 0);
        check("t1_active_low_when_idle", tx_active, 0);

        // Burst of 16 while UART is held busy: fills exactly, then drains in order
        force_hi = 1'b1;
        @(negedge clk);
        for (int unsigned i = 1; i <= 16; i++) put(8'(i), 1'b1);
        stop_wr();
        check("t2_full", full, 1);
        check("t2_count", count, 16);
        check("t2_no_overflow", overflow, 0);
        force_hi = 1'b0;
        drain("t2_drain");
        check("t2_queue_empty", exp_q.size(), 0);

        // Overflow: 17th byte dropped; set wins over clear; clear works alone
        do_reset();
        force_hi = 1'b1;
        @(negedge clk);
        for (int unsigned i = 0; i < 17; i++) put(8'h20 + 8'(i), i < 16);
        stop_wr();
        check("t3_count", count, 16);
        check("t3_overflow", overflow, 1);
        wr_en    = 1'b1;
        wr_data  = 8'hEE;
        flag_clr = 1'b1;
        @(negedge clk);
        wr_en    = 1'b0;
        flag_clr = 1'b0;
        check("t3_set_wins_over_clear", overflow, 1);
        pulse_clr();
        check("t3_overflow_cleared", overflow, 0);
        force_hi = 1'b0;
        drain("t3_drain");
        check("t3_queue_empty", exp_q.size(), 0);

        // Write in the pop cycle while full: dropped, count 16 -> 15
        force_hi = 1'b1;
        @(negedge clk);
        for (int unsigned i = 0; i < 16; i++) put(8'h40 + 8'(i), 1'b1);
        stop_wr();
        force_hi = 1'b0;
        wait_act(1'b0, "t4a_act_low");
        put(8'hAA, 1'b0);
        stop_wr();
        check("t4a_start", start_TX, 1);
        check("t4a_count", count, 15);
        check("t4a_overflow", overflow, 1);
        drain("t4a_drain");
        check("t4a_queue_empty", exp_q.size(), 0);
        pulse_clr();

        // Write in the pop cycle with count=5: accepted, count unchanged, sent last
        do_reset();
        force_hi = 1'b1;
        @(negedge clk);
        for (int unsigned i = 0; i < 5; i++) put(8'h50 + 8'(i), 1'b1);
        stop_wr();
        force_hi = 1'b0;
        wait_act(1'b0, "t4b_act_low");
        put(8'hAA, 1'b1);
        stop_wr();
        check("t4b_start", start_TX, 1);
        check("t4b_count", count, 5);
        check("t4b_overflow", overflow, 0);
        drain("t4b_drain");
        check("t4b_queue_empty", exp_q.size(), 0);

        // Timeout: LAUNCH cycle plus RISE_TIMEOUT cycles in WAIT_RISE, then next byte launches
        do_reset();
        never = 1'b1;
        @(negedge clk);
        put(8'h11, 1'b1);
        put(8'h22, 1'b1);
        stop_wr();
        wait_start("t5_first_start", t0);
        wait_timeout("t5_timeout", t1);
        check("t5_timeout_delay", t1 - t0, RISE_TIMEOUT + 1);
        wait_start("t5_second_start", t2);
        check("t5_next_launch_delay", t2 - t1, 1);
        drain("t5_drain");
        check("t5_timeout_sticky", tx_timeout, 1);
        pulse_clr();
        check("t5_timeout_cleared", tx_timeout, 0);
        never = 1'b0;
        check("t5_queue_empty", exp_q.size(), 0);

        // Reset mid-transfer: queue abandoned, in-flight UART byte keeps tx_busy high
        do_reset();
        @(negedge clk);
        for (int unsigned i = 0; i < 8; i++) put(8'h60 + 8'(i), i == 0);
        stop_wr();
        wait_act(1'b1, "t6_act_high");
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("t6_count", count, 0);
        check("t6_start", start_TX, 0);
        check("t6_overflow", overflow, 0);
        check("t6_timeout", tx_timeout, 0);
        check("t6_tx_data", tx_data, 0);
        check("t6_busy_during_active", tx_busy, 1);
        bad = 0;
        for (int unsigned i = 0; i < 40; i++) begin
            if (tx_busy !== tx_active) bad++;
            @(negedge clk);
        end
        check("t6_busy_follows_active", bad, 0);
        check("t6_busy_low", tx_busy, 0);
        check("t6_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
